rf_param: RTL and testbench
===========================

Name: rf_param

Overview:
- Parametrised successor to the 8x16 two-read/one-write register file.
- Width, depth and number of read ports are generic.
- Adds a per-register "written" scoreboard, address range checking on a real err output, and an optional write-to-read bypass.
- Sits in the decode stage of the pipelined core and is instantiated once per core.

Parameters:
- WIDTH, 16, data width of each register in bits.
- DEPTH, 8, number of registers; any value 2..2^ADDR_W.
- ADDR_W, 3, width of each register select field.
- NUM_RD, 2, number of independent read ports, 1..4.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- write  input  1  write enable.
- writeregsel  input  ADDR_W  write register select.
- writedata  input  WIDTH  write data.
- readregsel  input  NUM_RD*ADDR_W  read selects; port k occupies bits [k*ADDR_W +: ADDR_W].
- readdata  output  NUM_RD*WIDTH  read data; port k occupies bits [k*WIDTH +: WIDTH].
- written  output  DEPTH  bit i = register i has been written since reset.
- err  output  1  illegal address on an active port this cycle.

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high; it is sampled only on the rising edge of clk.
- Reset:
  - On a rising edge with rst=1, all DEPTH registers clear to 0 and written clears to all zeros.
  - write is ignored on that edge (reset has priority).
  - Reset asserted while a write is presented: the write is lost.
- Storage:
  - DEPTH registers of WIDTH bits, held in flops.
  - No hardwired-zero register; register 0 is ordinary storage.
- Write:
  - On a rising edge with rst=0, write=1 and writeregsel<DEPTH: reg[writeregsel] takes writedata, and written[writeregsel] is set.
  - Write latency is 1 cycle; the new value is visible to reads from the next cycle.
  - writeregsel>=DEPTH with write=1: no register or written bit changes.
- Read:
  - Combinational, zero latency; one mux per port.
  - readdata[k] = reg[readregsel[k]] when readregsel[k]<DEPTH, else 0.
  - Any number of ports may select the same register in the same cycle.
- written:
  - Sticky per register; cleared only by rst.
  - Driven directly from flops, with no combinational path from the inputs.
- err (combinational):
  - Asserts when write=1 and writeregsel>=DEPTH.
  - Also asserts when any readregsel[k]>=DEPTH; read ports are always treated as active.
  - When DEPTH=2^ADDR_W, err is constant 0.
  - err is not sticky. It is forced to 0 during a cycle where rst=1.
- Simultaneous write and read of the same register: behaviour depends on RF_BYPASS_EN (see Optional Feature).
- Outputs immediately after reset: readdata is 0 for every in-range select, written=0, and err depends only on the current inputs.

Optional Feature:
- Macro: RF_BYPASS_EN
- Defined:
  - Write-to-read bypass is enabled. In a cycle with rst=0, write=1, writeregsel<DEPTH and readregsel[k]==writeregsel, readdata[k]=writedata (combinational).
  - Ports with other selects are unaffected.
  - Used so the decode stage sees writeback data in the same cycle.
- Not defined:
  - readdata[k] returns the pre-edge stored value; the new value appears the following cycle.
  - No combinational path from writedata to readdata.

Test Plan:
- Reset then read: assert rst for 1 cycle, then rst=0 with readregsel={3'd7,3'd0} -> readdata=0x0000 on both ports, written=8'h00, err=0.
- Write then read: write=1, writeregsel=3, writedata=0xBEEF for 1 cycle; next cycle write=0, port0 sel=3, port1 sel=2 -> port0=0xBEEF, port1=0x0000, written=8'h08.
- Same-cycle read/write: reg 5 holds 0x1111; drive write=1, writeregsel=5, writedata=0x2222, port0 sel=5.
  - With RF_BYPASS_EN: port0=0x2222 in that cycle.
  - Without RF_BYPASS_EN: port0=0x1111 in that cycle, then 0x2222 the next cycle.
- Range check with DEPTH=6: write=1, writeregsel=6, writedata=0xAAAA -> err=1; on the next cycle no register changes and written is unchanged. Then port1 sel=7 with write=0 -> err=1, port1=0x0000.
- Reset mid-operation: fill regs 0..7 with 0x1000+i; assert rst in the same cycle as write=1, writeregsel=1, writedata=0xFFFF -> next cycle all reads return 0, written=8'h00.
- Parameter sweep with WIDTH=32, DEPTH=16, ADDR_W=4, NUM_RD=3: write 0xDEADBEEF to reg 15; three ports reading 15, 15, 0 -> 0xDEADBEEF, 0xDEADBEEF, 0x00000000; written=16'h8000.

Source files
------------

// File: rtl/rf_param.sv
// rf_param: parametrised multi-read, single-write register file.
//
// Storage is DEPTH registers of WIDTH bits held in flops. Register 0 is ordinary
// storage (no hardwired zero). Writes land on the rising edge of clk; reads are
// combinational with one mux per read port.
//
// Parameters:
//   WIDTH   data width of each register
//   DEPTH   number of registers, 2..2^ADDR_W
//   ADDR_W  width of each register select
//   NUM_RD  number of read ports, 1..4
//
// Ports:
//   clk          clock, rising edge
//   rst          synchronous active-high reset; clears registers and written
//   write        write enable
//   writeregsel  write register select
//   writedata    write data
//   readregsel   read selects, port k at [k*ADDR_W +: ADDR_W]
//   readdata     read data, port k at [k*WIDTH +: WIDTH]; 0 for out-of-range select
//   written      bit i set once register i has been written since reset
//   err          out-of-range select on the active write port or on any read port
//
// Build option:
//   RF_BYPASS_EN  when defined, a read of the register being written in the same
//                 cycle returns writedata combinationally.

module rf_param #(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned ADDR_W = 3,
    parameter int unsigned NUM_RD = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       write,
    input  logic [ADDR_W-1:0]          writeregsel,
    input  logic [WIDTH-1:0]           writedata,
    input  logic [NUM_RD*ADDR_W-1:0]   readregsel,
    output logic [NUM_RD*WIDTH-1:0]    readdata,
    output logic [DEPTH-1:0]           written,
    output logic                       err
);

    // DEPTH expressed one bit wider than a select so DEPTH = 2^ADDR_W is representable.
    localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W + 1)'(DEPTH);

    logic [WIDTH-1:0] regs_q [DEPTH];
    logic [DEPTH-1:0] written_q;

    function automatic logic in_range(input logic [ADDR_W-1:0] sel);
        return ({1'b0, sel} < DEPTH_W);
    endfunction

    // Storage and scoreboard. Reset wins over a simultaneous write; an
    // out-of-range write matches no register and so changes nothing.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                regs_q[i] <= '0;
            end
            written_q <= '0;
        end else if (write) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                if (writeregsel == ADDR_W'(i)) begin
                    regs_q[i]    <= writedata;
                    written_q[i] <= 1'b1;
                end
            end
        end
    end

    assign written = written_q;

    // Read muxes; a select with no matching register yields 0.
    always_comb begin
        readdata = '0;
        for (int k = 0; k < int'(NUM_RD); k++) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                if (readregsel[k*ADDR_W +: ADDR_W] == ADDR_W'(i)) begin
                    readdata[k*WIDTH +: WIDTH] = regs_q[i];
                end
            end
`ifdef RF_BYPASS_EN
            // Forward writeback data so decode sees it in the same cycle.
            if (!rst && write && in_range(writeregsel) &&
                (readregsel[k*ADDR_W +: ADDR_W] == writeregsel)) begin
                readdata[k*WIDTH +: WIDTH] = writedata;
            end
`endif
        end
    end

    // Range error; read ports always count as active. Held low while in reset.
    always_comb begin
        err = write && !in_range(writeregsel);
        for (int k = 0; k < int'(NUM_RD); k++) begin
            if (!in_range(readregsel[k*ADDR_W +: ADDR_W])) begin
                err = 1'b1;
            end
        end
        if (rst) begin
            err = 1'b0;
        end
    end

endmodule

// File: tb/tb_rf_param.sv
// Directed bench for rf_param: a default instance, a DEPTH=6 instance for range
// checking, and a 32x16, three-read-port instance. All share clk and rst.

module tb_rf_param;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    // Default instance: WIDTH=16, DEPTH=8, ADDR_W=3, NUM_RD=2
    logic        write = 1'b0;
    logic [2:0]  writeregsel = '0;
    logic [15:0] writedata = '0;
    logic [5:0]  readregsel = '0;
    logic [31:0] readdata;
    logic [7:0]  written;
    logic        err;

    // DEPTH=6 instance
    logic        w6 = 1'b0;
    logic [2:0]  ws6 = '0;
    logic [15:0] wd6 = '0;
    logic [5:0]  rs6 = '0;
    logic [31:0] rd6;
    logic [5:0]  wr6;
    logic        err6;

    // WIDTH=32, DEPTH=16, ADDR_W=4, NUM_RD=3 instance
    logic        ww = 1'b0;
    logic [3:0]  wsw = '0;
    logic [31:0] wdw = '0;
    logic [11:0] rsw = '0;
    logic [95:0] rdw;
    logic [15:0] wrw;
    logic        errw;

    rf_param u_dut (
        .clk         (clk),
        .rst         (rst),
        .write       (write),
        .writeregsel (writeregsel),
        .writedata   (writedata),
        .readregsel  (readregsel),
        .readdata    (readdata),
        .written     (written),
        .err         (err)
    );

    rf_param #(.WIDTH(16), .DEPTH(6), .ADDR_W(3), .NUM_RD(2)) u_d6 (
        .clk         (clk),
        .rst         (rst),
        .write       (w6),
        .writeregsel (ws6),
        .writedata   (wd6),
        .readregsel  (rs6),
        .readdata    (rd6),
        .written     (wr6),
        .err         (err6)
    );

    rf_param #(.WIDTH(32), .DEPTH(16), .ADDR_W(4), .NUM_RD(3)) u_wide (
        .clk         (clk),
        .rst         (rst),
        .write       (ww),
        .writeregsel (wsw),
        .writedata   (wdw),
        .readregsel  (rsw),
        .readdata    (rdw),
        .written     (wrw),
        .err         (errw)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance past the next rising edge; inputs change and outputs are sampled here.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset then read
        rst = 1'b1;
        tick();
        rst = 1'b0;
        readregsel = {3'd7, 3'd0};
        #1;
        check("rst_rd0", 64'(readdata[15:0]), 64'h0);
        check("rst_rd1", 64'(readdata[31:16]), 64'h0);
        check("rst_written", 64'(written), 64'h00);
        check("rst_err", 64'(err), 64'h0);
        check("rst_written6", 64'(wr6), 64'h00);

        // Write then read
        write = 1'b1; writeregsel = 3'd3; writedata = 16'hBEEF;
        tick();
        write = 1'b0;
        readregsel = {3'd2, 3'd3};
        #1;
        check("wr_rd0", 64'(readdata[15:0]), 64'hBEEF);
        check("wr_rd1", 64'(readdata[31:16]), 64'h0000);
        check("wr_written", 64'(written), 64'h08);

        // Same-cycle read/write of register 5
        write = 1'b1; writeregsel = 3'd5; writedata = 16'h1111;
        tick();
        writedata = 16'h2222;
        readregsel = {3'd3, 3'd5};
        #1;
`ifdef RF_BYPASS_EN
        check("same_rd0", 64'(readdata[15:0]), 64'h2222);
`else
        check("same_rd0", 64'(readdata[15:0]), 64'h1111);
`endif
        check("same_rd1", 64'(readdata[31:16]), 64'hBEEF);
        tick();
        write = 1'b0;
        #1;
        check("next_rd0", 64'(readdata[15:0]), 64'h2222);
        check("next_written", 64'(written), 64'h28);

        // Range check on the DEPTH=6 instance
        w6 = 1'b1; ws6 = 3'd0; wd6 = 16'h1234;
        tick();
        ws6 = 3'd6; wd6 = 16'hAAAA;
        #1;
        check("oor_wr_err", 64'(err6), 64'h1);
        tick();
        w6 = 1'b0;
        rs6 = {3'd5, 3'd0};
        #1;
        check("oor_err_clear", 64'(err6), 64'h0);
        check("oor_written", 64'(wr6), 64'h01);
        check("oor_reg0", 64'(rd6[15:0]), 64'h1234);
        for (int i = 1; i < 6; i++) begin
            rs6 = {3'd0, 3'(i)};
            #1;
            check($sformatf("oor_reg%0d", i), 64'(rd6[15:0]), 64'h0);
        end
        rs6 = {3'd7, 3'd0};
        #1;
        check("oor_rd_err", 64'(err6), 64'h1);
        check("oor_rd1", 64'(rd6[31:16]), 64'h0);
        rs6 = {3'd0, 3'd6};
        #1;
        check("oor_rd0_err", 64'(err6), 64'h1);
        check("oor_rd0", 64'(rd6[15:0]), 64'h0);

        // Reset mid-operation; the DEPTH=6 instance still sees an illegal select
        for (int i = 0; i < 8; i++) begin
            write = 1'b1; writeregsel = 3'(i); writedata = 16'h1000 + 16'(i);
            tick();
        end
        write = 1'b0;
        readregsel = {3'd7, 3'd1};
        #1;
        check("fill_rd0", 64'(readdata[15:0]), 64'h1001);
        check("fill_rd1", 64'(readdata[31:16]), 64'h1007);
        check("fill_written", 64'(written), 64'hFF);
        rst = 1'b1;
        write = 1'b1; writeregsel = 3'd1; writedata = 16'hFFFF;
        rs6 = {3'd7, 3'd0};
        #1;
        check("rst_err6_forced", 64'(err6), 64'h0);
        tick();
        rst = 1'b0;
        write = 1'b0;
        for (int i = 0; i < 8; i++) begin
            readregsel = {3'(7 - i), 3'(i)};
            #1;
            check($sformatf("mid_rst_rd%0d", i), 64'(readdata), 64'h0);
        end
        check("mid_rst_written", 64'(written), 64'h00);
        check("mid_rst_err6", 64'(err6), 64'h1);
        rs6 = '0;

        // Wider parameter set
        ww = 1'b1; wsw = 4'd15; wdw = 32'hDEADBEEF;
        tick();
        ww = 1'b0;
        rsw = {4'd0, 4'd15, 4'd15};
        #1;
        check("wide_rd0", 64'(rdw[31:0]), 64'hDEADBEEF);
        check("wide_rd1", 64'(rdw[63:32]), 64'hDEADBEEF);
        check("wide_rd2", 64'(rdw[95:64]), 64'h00000000);
        check("wide_written", 64'(wrw), 64'h8000);
        check("wide_err", 64'(errw), 64'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
